// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//
// Frame-level sequencer for the 3x3 convolution front end. It accepts a
// raster-order pixel stream and tracks the (row, col) position of each
// accepted pixel. It drives the line-buffer write on the accept, and drives
// the window-buffer push one cycle later to line up with the line buffer's
// read latency. Alongside the push it emits a tag that marks the pushes which
// close a legal, non-wrapping 3x3 window. The pixel source is stalled
// whenever the downstream consumer is not ready.
//
// Parameters
//   IMG_W, IMG_H  image width / height in pixels (each >= 3)
//   COL_W, ROW_W  column / row counter widths
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   start        begins a frame; honoured only while idle
//   pix_valid    source has a pixel
//   pix_ready    controller accepts a pixel (combinational)
//   ds_ready     downstream can take a window this cycle
//   lb_wr_en     line buffer write, equal to the accept (combinational)
//   wb_in_valid  window buffer push, the accept delayed by one cycle
//   tag_valid    the push closes a legal 3x3 window
//   tag_row      top-left row of that window, 0 when untagged
//   tag_col      top-left column of that window, 0 when untagged
//   busy         a frame is in progress
//   done         one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             ds_ready,
    output logic             lb_wr_en,
    output logic             wb_in_valid,
    output logic             tag_valid,
    output logic [ROW_W-1:0] tag_row,
    output logic [COL_W-1:0] tag_col,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [1:0]       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic             r_push_vld_p1;
    logic             r_tag_vld_p1;
    logic [ROW_W-1:0] r_tag_row_p1;
    logic [COL_W-1:0] r_tag_col_p1;
    logic             r_done;

    logic             w_pix_ready;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_win_hit;
    logic             w_tag_vld_p0;

    // ---- stage p0: accept and position decode -----------------------------
    assign w_pix_ready  = (r_state == S_RUN) && ds_ready;
    assign w_accept     = w_pix_ready && pix_valid;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);

    // The current pixel is the bottom-right corner of a window whose top-left
    // corner is two rows up and two columns left. Columns 0 and 1 would pair
    // with pixels from the previous row, so those windows are masked.
    assign w_win_hit    = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_tag_vld_p0 = w_accept && w_win_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                // Last pixel of the frame: one flush cycle
                                // lets its window-buffer push go out.
                                r_row   <= '0;
                                r_state <= S_FLUSH;
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- stage p1: window-buffer push, tag and completion pulse -----------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_push_vld_p1 <= 1'b0;
            r_tag_vld_p1  <= 1'b0;
            r_tag_row_p1  <= '0;
            r_tag_col_p1  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_push_vld_p1 <= w_accept;
            r_tag_vld_p1  <= w_tag_vld_p0;
            r_tag_row_p1  <= w_tag_vld_p0 ? (r_row - ROW_TWO) : '0;
            r_tag_col_p1  <= w_tag_vld_p0 ? (r_col - COL_TWO) : '0;
            r_done        <= (r_state == S_FLUSH);
        end
    end

    assign pix_ready   = w_pix_ready;
    assign lb_wr_en    = w_accept;
    assign wb_in_valid = r_push_vld_p1;
    assign tag_valid   = r_tag_vld_p1;
    assign tag_row     = r_tag_row_p1;
    assign tag_col     = r_tag_col_p1;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;

    localparam int W     = 5;
    localparam int H     = 4;
    localparam int N     = W * H;
    localparam int COL_W = $clog2(W);
    localparam int ROW_W = $clog2(H);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             pix_valid;
    logic             pix_ready;
    logic             ds_ready;
    logic             lb_wr_en;
    logic             wb_in_valid;
    logic             tag_valid;
    logic [ROW_W-1:0] tag_row;
    logic [COL_W-1:0] tag_col;
    logic             busy;
    logic             done;

    conv_window_ctrl #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .ds_ready   (ds_ready),
        .lb_wr_en   (lb_wr_en),
        .wb_in_valid(wb_in_valid),
        .tag_valid  (tag_valid),
        .tag_row    (tag_row),
        .tag_col    (tag_col),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: a frame is "in progress" and has taken m_k pixels.
    // Once all N pixels are in, one more cycle drains the last push.
    bit m_in_frame = 1'b0;
    int m_k        = 0;
    bit m_wbv      = 1'b0;
    bit m_tagv     = 1'b0;
    int m_tagr     = 0;
    int m_tagc     = 0;
    bit m_done     = 1'b0;

    // Per-frame observations
    int obs_acc      = 0;
    int done_cnt     = 0;
    int last_acc_cyc = 0;
    int done_cyc     = 0;
    int tag_q[$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d required %0d (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic tick(input bit rst, input bit st, input bit pv, input bit dr);
        bit exp_rdy;
        bit exp_acc;
        int row;
        int col;
        reset     = rst;
        start     = st;
        pix_valid = pv;
        ds_ready  = dr;
        @(negedge clk);
        exp_rdy = m_in_frame && (m_k < N) && dr;
        exp_acc = exp_rdy && pv;
        chk("pix_ready",   32'(pix_ready),   32'(exp_rdy));
        chk("lb_wr_en",    32'(lb_wr_en),    32'(exp_acc));
        chk("wb_in_valid", 32'(wb_in_valid), 32'(m_wbv));
        chk("tag_valid",   32'(tag_valid),   32'(m_tagv));
        chk("tag_row",     32'(tag_row),     32'(m_tagr));
        chk("tag_col",     32'(tag_col),     32'(m_tagc));
        chk("busy",        32'(busy),        32'(m_in_frame));
        chk("done",        32'(done),        32'(m_done));
        if (lb_wr_en === 1'b1) begin
            obs_acc++;
            last_acc_cyc = cyc;
        end
        if (tag_valid === 1'b1) tag_q.push_back(int'(tag_row) * 16 + int'(tag_col));
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            m_in_frame = 1'b0;
            m_k        = 0;
            m_wbv      = 1'b0;
            m_tagv     = 1'b0;
            m_tagr     = 0;
            m_tagc     = 0;
            m_done     = 1'b0;
        end else begin
            row    = m_k / W;
            col    = m_k % W;
            m_wbv  = exp_acc;
            m_tagv = exp_acc && (row >= 2) && (col >= 2);
            m_tagr = m_tagv ? row - 2 : 0;
            m_tagc = m_tagv ? col - 2 : 0;
            m_done = m_in_frame && (m_k == N);
            if (m_in_frame && (m_k == N)) begin
                m_in_frame = 1'b0;
            end else if (!m_in_frame && st) begin
                m_in_frame = 1'b1;
                m_k        = 0;
            end else if (exp_acc) begin
                m_k++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: full rate, 1: 3-cycle stall after accept #8, 2: source bubbles,
    // 3: random valid/ready with stray starts, 4: start pulsed mid-frame
    task automatic run_frame(input int mode, output int len);
        int start_cyc;
        int budget;
        int stall_left;
        int n_exp;
        bit tgl;
        bit pv;
        bit dr;
        bit st;
        obs_acc  = 0;
        done_cnt = 0;
        done_cyc = 0;
        tag_q.delete();
        start_cyc  = cyc;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tgl        = 1'b1;
        stall_left = 3;
        budget     = 0;
        while (done_cnt == 0 && budget < 400) begin
            pv = 1'b1;
            dr = 1'b1;
            st = 1'b0;
            case (mode)
                1: if (obs_acc == 8 && stall_left > 0) begin
                    dr = 1'b0;
                    stall_left--;
                end
                2: begin
                    pv  = tgl;
                    tgl = !tgl;
                end
                3: begin
                    pv = ($urandom % 4) != 0;
                    dr = ($urandom % 4) != 0;
                    st = (obs_acc < N) && (($urandom % 8) == 0);
                end
                4: st = (obs_acc == 5);
                default: ;
            endcase
            tick(1'b0, st, pv, dr);
            budget++;
        end
        len = done_cyc - start_cyc;
        chk("frame_done_count", 32'(done_cnt), 32'd1);
        chk("frame_accepts", 32'(obs_acc), 32'(N));
        chk("done_after_last_accept", 32'(done_cyc - last_acc_cyc), 32'd2);
        n_exp = (W - 2) * (H - 2);
        chk("tag_count", 32'(tag_q.size()), 32'(n_exp));
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                int idx;
                idx = r * (W - 2) + c;
                if (idx < tag_q.size()) chk("tag_position", 32'(tag_q[idx]), 32'(r * 16 + c));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int b;
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        ds_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with start/pix_valid active: everything stays 0
        repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b1);

        // pix_valid while idle is not accepted
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b1);

        run_frame(0, len);
        chk("frame_len_full", 32'(len), 32'(N + 2));

        run_frame(1, len);
        chk("frame_len_stall", 32'(len), 32'(N + 5));

        run_frame(2, len);
        chk("frame_len_bubble", 32'(len), 32'(2 * N + 1));

        // Mid-frame reset after accept #11: frame abandoned, no done
        obs_acc  = 0;
        done_cnt = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        b = 0;
        while (obs_acc < 11 && b < 50) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            b++;
        end
        chk("midreset_accepts", 32'(obs_acc), 32'd11);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b1);
        chk("midreset_no_done", 32'(done_cnt), 32'd0);

        run_frame(0, len);
        chk("frame_len_after_reset", 32'(len), 32'(N + 2));

        run_frame(4, len);
        chk("frame_len_misuse_start", 32'(len), 32'(N + 2));

        repeat (5) begin
            run_frame(3, len);
            repeat ($urandom % 3) tick(1'b0, 1'b0, 1'b1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Frame-level sequencer for the 3x3 convolution front end. It accepts a raster-order pixel stream, drives the line buffer write enable and the window buffer `in_valid`, and tracks the row and column position. It also emits a registered tag that marks which window-buffer pushes complete a legal, non-wrapping 3x3 window. It sits between the pixel source and the line buffer + window buffer pair, and stalls the source when the downstream MAC array is not ready.

## Interface
Parameters:
- `IMG_W`, default 28: image width in pixels; must be ≥ 3.
- `IMG_H`, default 28: image height in pixels; must be ≥ 3.
- `COL_W`, default `$clog2(IMG_W)`: column counter width.
- `ROW_W`, default `$clog2(IMG_H)`: row counter width.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  pulse that begins a frame; honoured only in IDLE.
- `pix_valid`  in  1  source has a pixel.
- `pix_ready`  out  1  controller accepts a pixel. Combinational: `(state==RUN) && ds_ready`.
- `ds_ready`  in  1  downstream (MAC / window consumer) can take a window this cycle.
- `lb_wr_en`  out  1  line buffer write. Combinational: `pix_valid && pix_ready` (the accept).
- `wb_in_valid`  out  1  window buffer push. Registered copy of accept, one cycle later.
- `tag_valid`  out  1  registered, coincident with `wb_in_valid`. High when the push closes a legal window.
- `tag_row`  out  ROW_W  top-left row of the window when `tag_valid`, else 0.
- `tag_col`  out  COL_W  top-left column of the window when `tag_valid`, else 0.
- `busy`  out  1  `state != IDLE`.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- State machine states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start`. Counters `col` and `row` are cleared to 0 on entry.
  - RUN: each accept advances the position.
    - `col` increments; at `IMG_W-1` it wraps to 0 and `row` increments.
    - The accept of pixel (`IMG_H-1`, `IMG_W-1`) moves the state to FLUSH, and the counters return to 0.
  - FLUSH: lasts one cycle, during which the last `wb_in_valid` is issued. Then the state goes to IDLE and `done` is 1 for that single IDLE cycle.
- Tag rule, evaluated on the accepted pixel at (`row`, `col`):
  - `tag_valid` = `row ≥ 2 && col ≥ 2`.
  - `tag_row` = `row-2`, `tag_col` = `col-2`.
  - Pushes at `col` 0 or 1 are untagged. This masks the windows that straddle a row wrap.
- Windows per frame: exactly `(IMG_W-2)*(IMG_H-2)` tagged pushes. Pixels per frame: exactly `IMG_W*IMG_H` accepts.
- Stall: `ds_ready`=0 forces `pix_ready`=0. Counters and state hold, and no pushes are issued. A `wb_in_valid` already registered still issues the next cycle.
- `start` while busy: ignored. `pix_valid` in IDLE or FLUSH: not accepted, `pix_ready`=0.
- Reset (including mid-frame): state → IDLE, counters → 0. All outputs go to 0: `busy`, `done`, `wb_in_valid`, `tag_valid`, `tag_row`, `tag_col`, and via the state also `pix_ready` and `lb_wr_en`. A partial frame is abandoned with no `done`.

## Timing
- Accept at cycle T produces `lb_wr_en` at T and `wb_in_valid` plus tag at T+1. This matches the one-cycle read latency of the line buffer.
- Last-pixel accept at T:
  - FLUSH at T+1, with the final `wb_in_valid`.
  - IDLE at T+2, with `done`=1 and `busy`=0.
  - `done`=0 at T+3.
- `start` at T gives RUN at T+1. The earliest accept is at T+1.
- The back-to-back frame minimum gap is 1 cycle: `start` is sampled in the `done` cycle.
- Throughput: one pixel per cycle while `pix_valid` and `ds_ready` are both held high.

## Test plan
- Reset check: with `IMG_W`=5, `IMG_H`=4, hold `reset` high → every output is 0 and `pix_ready`=0 even with `pix_valid`=1.
- Full frame: `IMG_W`=5, `IMG_H`=4, `start`, then `pix_valid` held high for 20 cycles.
  - 20 `lb_wr_en` pulses.
  - 6 `tag_valid` pushes, with (`tag_row`,`tag_col`) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - `done` exactly 2 cycles after the 20th accept.
- Stall: same frame, with `ds_ready`=0 for 3 cycles after accept #8.
  - `pix_ready`=0 for those 3 cycles.
  - No `lb_wr_en` in that window.
  - Tag sequence unchanged, and `done` delayed by exactly 3 cycles.
- Source bubbles: toggle `pix_valid` 1/0 → 20 accepts and 6 tags. `wb_in_valid` always follows each accept by exactly 1 cycle.
- Mid-frame reset: `reset` after accept #11 → all outputs 0 next cycle and no `done`. A new `start` then completes a clean 20-pixel frame with tags starting at (0,0).
- Misuse: `start` pulsed during RUN and `pix_valid`=1 in IDLE → both ignored. Frame count and tags are unaffected.
